// File: rtl/dmem_responder_if.sv
// Bus between the MEM-stage pipeline logic and the data-memory responder.
// The pipeline side drives the request strobes, address, store data and
// access size; the responder returns stall, load data and status pulses.
interface dmem_responder_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic        stall;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  // Pipeline / controller side
  modport master (
    output memread,
    output memwrite,
    output addr,
    output wdata,
    output funct3,
    input  stall,
    input  rdata,
    input  rvalid,
    input  err
  );

  // Data-memory responder side
  modport slave (
    input  memread,
    input  memwrite,
    input  addr,
    input  wdata,
    input  funct3,
    output stall,
    output rdata,
    output rvalid,
    output err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage of the RV32 pipeline.
// Accepts one load or store at a time, waits LATENCY cycles, then accesses
// a word-organised SRAM. Stall is held from acceptance until the access
// completes. Loads return sign/zero-extended data with a one-cycle rvalid
// pulse; malformed requests are rejected with a one-cycle err pulse.
module dmem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]       state;
  logic [3:0]       cnt;

  // Request captured at acceptance; the pipeline inputs are not used again
  // until the responder returns to IDLE.
  logic [IDX_W-1:0] a_idx;
  logic [1:0]       a_lo;
  logic [31:0]      wd;
  logic [2:0]       f3;
  logic             op_wr;

  logic [31:0]      mem [DEPTH];

  logic             req;
  logic             bad;
  logic             accept;
  logic             fire;
  logic [31:0]      rd_word;
  logic [31:0]      sh_word;
  logic [31:0]      ld_val;
  logic [31:0]      wd_rep;
  logic [3:0]       be;
  logic [31:0]      wr_word;

  // Upper address bits alias onto the array and are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[31:ADDR_W];

  // Request decode: legality of the incoming access
  always_comb begin
    req = bus.memread | bus.memwrite;
    bad = 1'b0;
    if (bus.memread && bus.memwrite)
      bad = 1'b1;
    if (bus.funct3[1:0] == 2'b01 && bus.addr[0])
      bad = 1'b1;
    if (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00)
      bad = 1'b1;
    if (bus.memread &&
        !(bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
      bad = 1'b1;
    if (bus.memwrite && !(bus.funct3 inside {F3_B, F3_H, F3_W}))
      bad = 1'b1;
  end

  assign accept = (state == S_IDLE) && req && !bad;
  assign fire   = (state == S_BUSY) && (cnt == 4'd0);

  // Stall is gated by reset so the pipeline is released the moment reset rises
  assign bus.stall = !rst && (accept || (state == S_BUSY));

  // Load path: word read, lane select, sign/zero extension
  always_comb begin
    rd_word = mem[a_idx];
    sh_word = rd_word >> {a_lo, 3'b000};
    case (f3)
      F3_B:    ld_val = {{24{sh_word[7]}}, sh_word[7:0]};
      F3_H:    ld_val = {{16{sh_word[15]}}, sh_word[15:0]};
      F3_BU:   ld_val = {24'd0, sh_word[7:0]};
      F3_HU:   ld_val = {16'd0, sh_word[15:0]};
      default: ld_val = rd_word;
    endcase
  end

  // Store path: replicate data across lanes and merge under byte enables
  always_comb begin
    case (f3[1:0])
      2'b00: begin
        wd_rep = {4{wd[7:0]}};
        be     = 4'b0001 << a_lo;
      end
      2'b01: begin
        wd_rep = {2{wd[15:0]}};
        be     = a_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wd_rep = wd;
        be     = 4'b1111;
      end
    endcase
    wr_word = rd_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i])
        wr_word[8*i +: 8] = wd_rep[8*i +: 8];
    end
  end

  // Array write on the access edge; an aborted store never reaches here
  always_ff @(posedge clk) begin
    if (fire && op_wr && !rst)
      mem[a_idx] <= wr_word;
  end

  // Control FSM, wait counter, request capture and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      a_idx      <= '0;
      a_lo       <= '0;
      wd         <= '0;
      f3         <= '0;
      op_wr      <= 1'b0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            if (bad) begin
              bus.err <= 1'b1;
            end else begin
              a_idx <= bus.addr[ADDR_W-1:2];
              a_lo  <= bus.addr[1:0];
              wd    <= bus.wdata;
              f3    <= bus.funct3;
              op_wr <= bus.memwrite;
              cnt   <= CNT_INIT;
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (cnt == 4'd0) begin
            state <= S_DONE;
            if (!op_wr) begin
              bus.rdata  <= ld_val;
              bus.rvalid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        // Inputs still describe the finished instruction here, so ignore them
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder with a behavioural
// memory model built from the access rules (byte lanes, extension,
// alignment/legality and the LATENCY+1 stall length).
module tb_dmem_responder;

  localparam int ADDR_W  = 12;
  localparam int LATENCY = 2;

  logic clk;
  logic rst;

  dmem_responder_if bus ();

  dmem_responder #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mmem [1 << (ADDR_W - 2)];
  logic [31:0] exp_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_bad(input logic mr, input logic mw,
                                     input logic [31:0] a, input logic [2:0] f3);
    logic legal_ld, legal_st, half, word;
    legal_ld = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    legal_st = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    half     = (f3 == 3'd1) || (f3 == 3'd5);
    word     = (f3 == 3'd2);
    return (mr && mw) || (half && a[0]) || (word && (a % 4 != 0)) ||
           (mr && !legal_ld) || (mw && !legal_st);
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] a,
                                              input logic [31:0] wd, input logic [2:0] f3);
    int unsigned sh;
    logic [31:0] mask, data;
    sh = 8 * (a % 4);
    if (f3 == 3'd0) begin
      mask = 32'hFF << sh;
      data = (wd & 32'hFF) << sh;
    end else if (f3 == 3'd1) begin
      mask = 32'hFFFF << sh;
      data = (wd & 32'hFFFF) << sh;
    end else begin
      mask = 32'hFFFF_FFFF;
      data = wd;
    end
    return (word & ~mask) | (data & mask);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [2:0] f3);
    logic [31:0] v;
    v = word >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 128)   v = v - 32'd256;   end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v - 32'd65536; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic drive(input logic mr, input logic mw, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    bus.memread  = mr;
    bus.memwrite = mw;
    bus.addr     = a;
    bus.wdata    = wd;
    bus.funct3   = f3;
  endtask

  // Called at posedge+1 with the responder idle; returns at posedge+1.
  task automatic idle_cycle();
    drive(1'b0, 1'b0, $urandom, $urandom, 3'($urandom));
    @(negedge clk);
    check("idle_stall", 32'(bus.stall), 32'd0);
    check("idle_err", 32'(bus.err), 32'd0);
    check("idle_rvalid", 32'(bus.rvalid), 32'd0);
    @(posedge clk); #1;
  endtask

  // One pipeline access: request held through DONE, released at the edge
  // ending DONE. Called and returns at posedge+1.
  task automatic access(input logic mr, input logic mw, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3);
    int n;
    int unsigned idx;
    idx = (a >> 2) % (1 << (ADDR_W - 2));
    drive(mr, mw, a, wd, f3);
    @(negedge clk);
    check("pre_err", 32'(bus.err), 32'd0);
    if (model_bad(mr, mw, a, f3)) begin
      check("bad_stall", 32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      @(negedge clk);
      check("bad_err", 32'(bus.err), 32'd1);
      check("bad_stall2", 32'(bus.stall), 32'd0);
      check("bad_rvalid", 32'(bus.rvalid), 32'd0);
      check("bad_rdata", bus.rdata, exp_rdata);
      @(posedge clk); #1;
    end else begin
      n = 0;
      while (bus.stall === 1'b1 && n < 40) begin
        n++;
        @(negedge clk);
      end
      check("stall_cycles", 32'(n), 32'(LATENCY + 1));
      check("done_err", 32'(bus.err), 32'd0);
      check("done_rvalid", 32'(bus.rvalid), 32'(mr));
      if (mr) exp_rdata = model_load(mmem[idx], a, f3);
      else    mmem[idx] = model_store(mmem[idx], a, wd, f3);
      check("rdata", bus.rdata, exp_rdata);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int unsigned r;

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    exp_rdata = 32'd0;
    #1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Word store/load round trip
    access(1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 3'd2);
    access(1'b1, 1'b0, 32'h010, 32'h0, 3'd2);
    check("lw_deadbeef", bus.rdata, 32'hDEADBEEF);

    // Byte store and signed/unsigned byte loads
    access(1'b0, 1'b1, 32'h020, 32'h0, 3'd2);
    access(1'b0, 1'b1, 32'h023, 32'h80, 3'd0);
    access(1'b1, 1'b0, 32'h023, 32'h0, 3'd0);
    check("lb_80", bus.rdata, 32'hFFFFFF80);
    access(1'b1, 1'b0, 32'h023, 32'h0, 3'd4);
    check("lbu_80", bus.rdata, 32'h00000080);
    access(1'b1, 1'b0, 32'h020, 32'h0, 3'd2);
    check("lw_byte", bus.rdata, 32'h80000000);

    // Halfword store over an existing word
    access(1'b0, 1'b1, 32'h030, 32'h11223344, 3'd2);
    access(1'b0, 1'b1, 32'h032, 32'h8001, 3'd1);
    access(1'b1, 1'b0, 32'h032, 32'h0, 3'd1);
    check("lh_8001", bus.rdata, 32'hFFFF8001);
    access(1'b1, 1'b0, 32'h032, 32'h0, 3'd5);
    check("lhu_8001", bus.rdata, 32'h00008001);
    access(1'b1, 1'b0, 32'h030, 32'h0, 3'd2);
    check("lw_half", bus.rdata, 32'h80013344);

    // Rejected requests
    access(1'b1, 1'b0, 32'h005, 32'h0, 3'd1);
    access(1'b1, 1'b0, 32'h006, 32'h0, 3'd2);
    access(1'b1, 1'b1, 32'h010, 32'h55555555, 3'd2);
    access(1'b1, 1'b0, 32'h010, 32'h0, 3'd3);
    access(1'b0, 1'b1, 32'h012, 32'h77777777, 3'd2);
    access(1'b1, 1'b0, 32'h010, 32'h0, 3'd2);
    check("lw_after_bad", bus.rdata, 32'hDEADBEEF);

    // Reset during BUSY aborts the store
    access(1'b0, 1'b1, 32'h040, 32'h12345678, 3'd2);
    drive(1'b0, 1'b1, 32'h040, 32'hAAAAAAAA, 3'd2);
    @(negedge clk);
    check("abort_stall_idle", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_stall_busy", 32'(bus.stall), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_stall_rst", 32'(bus.stall), 32'd0);
    check("abort_rdata_rst", bus.rdata, 32'd0);
    exp_rdata = 32'd0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    access(1'b1, 1'b0, 32'h040, 32'h0, 3'd2);
    check("lw_after_abort", bus.rdata, 32'h12345678);

    // Address aliasing
    access(1'b0, 1'b1, 32'h040, 32'h5A5A5A5A, 3'd2);
    access(1'b1, 1'b0, 32'h1040, 32'h0, 3'd2);
    check("lw_alias", bus.rdata, 32'h5A5A5A5A);
    idle_cycle();

    // Fill a small region, then random traffic with random upper bits
    for (int w = 0; w < 32; w++)
      access(1'b0, 1'b1, 32'(w * 4), $urandom, 3'd2);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 127));
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end else begin
        f3 = 3'($urandom);
      end
      if (r < 45)       access(1'b1, 1'b0, a, $urandom, f3);
      else if (r < 90)  access(1'b0, 1'b1, a, $urandom, f3);
      else if (r < 95)  access(1'b1, 1'b1, a, $urandom, f3);
      else              idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
